sprites_extra_shifter: RTL and testbench
========================================

Name: sprites_extra_shifter

Overview:
- Pixel-side consumer of the extra-sprite lookup interface (spr_found, tile planes, index, palette, priority).
- On each horizontal position where an extra sprite matches, it loads the sprite's 8 pixels into a per-pixel slot shifter, applying DMG/CGB overlap priority.
- It shifts one slot out per pixel and merges the result with the main 10-sprite pixel.
- It sits between the extra-sprite store and the final sprite/BG mixer.

Parameters:
- SPRITES_EXTRA, 6, maximum extra sprites per line; saturation value of load_count.
- INDEX_W, 4, width of the sprite index field.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; all state updates qualify on ce
- extra_spr_en  in  1  extra-sprite feature enable
- cgb_mode  in  1  1 = CGB priority rules (lower index wins); 0 = DMG rules
- line_start  in  1  clears shifter, guard and counter for a new line
- pix_shift  in  1  advance one pixel this cycle
- spr_found  in  1  extra sprite matches the current h position
- spr_tile0  in  8  tile low bitplane, bit 7 = leftmost pixel
- spr_tile1  in  8  tile high bitplane
- spr_xflip  in  1  horizontal flip
- spr_index  in  INDEX_W  sprite index (10..15)
- spr_pal  in  1  DMG palette select
- spr_prio  in  1  BG-over-OBJ priority
- spr_cgb_pal  in  3  CGB palette
- main_color  in  2  main sprite pixel colour (0 = transparent)
- main_pal, main_prio  in  1 each  main pixel attributes
- main_cgb_pal  in  3  main pixel CGB palette
- main_index  in  INDEX_W  main pixel sprite index
- out_color  out  2  merged pixel colour
- out_pal, out_prio  out  1 each  merged pixel attributes
- out_cgb_pal  out  3  merged pixel CGB palette
- out_index  out  INDEX_W  merged pixel sprite index
- out_extra  out  1  1 = output pixel came from the extra path
- load_count  out  3  extra sprites loaded this line, saturating at SPRITES_EXTRA

Behaviour:
- State
  - 8 slots, each holding {color[1:0], pal, prio, cgb_pal[2:0], index}.
  - Slot 0 is the current pixel.
  - load_guard flag and load_count register.
- Reset (reset_n=0, asynchronous)
  - All slots cleared: color 0, all attributes 0.
  - load_guard=0, load_count=0.
  - All outputs 0.
- Per ce cycle, in this order: line_start, then shift, then load.
- line_start=1
  - Clears slots, load_guard and load_count.
  - Overrides shift and load in the same cycle.
- Shift (pix_shift=1)
  - Slot i takes slot i+1; slot 7 becomes transparent.
  - Clears load_guard.
- Load qualifier: ld = spr_found & extra_spr_en & ~load_guard & ~line_start.
- Load operation (when ld)
  - Operates on post-shift contents.
  - Pixel colour for slot i = {spr_tile1[b], spr_tile0[b]}, where b = spr_xflip ? i : 7-i.
  - Slot i is overwritten when incoming colour ≠ 0 and either:
    - slot colour = 0, or
    - cgb_mode=1 and spr_index < slot index.
  - DMG: existing opaque slot is kept (earlier X wins).
  - Sets load_guard=1, so spr_found held across cycles without a shift loads once per position.
  - load_count increments, saturating at SPRITES_EXTRA.
  - load_count is incremented even if no slot is written (all-transparent tile).
- Merge (registered, 1 ce-cycle latency from slot 0 / main_* to out_*)
  - extra_spr_en=0 or main_color ≠ 0: out_* = main_*, out_extra=0.
  - Otherwise: out_* = slot 0 fields, out_extra = (slot0 color ≠ 0).
  - Main sprites always win because their OAM indices are lower.
- ce=0: all state and outputs hold.
- extra_spr_en dropping mid-line: no new loads; slots keep shifting out but are masked at the merge.

Test Plan:
1. Reset then idle → all outputs 0, load_count=0; assert reset_n low mid-line with slots loaded → slots clear immediately without clk.
2. DMG, spr_found with tile0=0xF0, tile1=0x00, index=10, then 8 shifts → out_color sequence 1,1,1,1,0,0,0,0 with out_extra=1, 1 cycle after each slot-0 value.
3. xflip=1, tile0=0x01, tile1=0x01 → first output pixel colour 3, remaining 7 transparent.
4. Overlap: load index 11 tile 0xFF/0x00, shift 2, load index 10 tile 0xFF/0xFF → DMG: pixels 0-5 colour 1 index 11, pixels 6-7 colour 3 index 10; CGB: pixels 0-5 colour 3 index 10.
5. spr_found held 3 cycles without pix_shift → single load, load_count=1; 8 loads on a line → load_count=6; line_start → load_count=0, slots empty.
6. main_color=2 over opaque extra slot → out_color=2, out_extra=0; line_start with ld and pix_shift in the same cycle → slots cleared, no load.

Source files
------------

// File: rtl/sprites_extra_shifter.sv
`default_nettype none
// ============================================================================
// Module   : sprites_extra_shifter
// Purpose  : Pixel-side shifter for the extra-sprite path. Each matching
//            extra sprite has its 8 pixels loaded into an 8-slot per-pixel
//            shifter. The load applies DMG or CGB overlap priority. One slot
//            is shifted out per pixel and merged with the main 10-sprite
//            pixel. The merged result is registered.
// Ports    : clk, reset_n (async, active-low), ce (clock enable)
//            extra_spr_en, cgb_mode          - feature enable, priority mode
//            line_start, pix_shift           - line clear, pixel advance
//            spr_*                           - extra sprite lookup result
//            main_*                          - main sprite pixel
//            out_*                           - merged pixel (1 ce-cycle latency)
//            load_count                      - extra sprites loaded this line
// Revision : 1.0 - initial release
// ============================================================================
module sprites_extra_shifter #(
    parameter int SPRITES_EXTRA = 6,
    parameter int INDEX_W       = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic               extra_spr_en,
    input  logic               cgb_mode,
    input  logic               line_start,
    input  logic               pix_shift,
    input  logic               spr_found,
    input  logic [7:0]         spr_tile0,
    input  logic [7:0]         spr_tile1,
    input  logic               spr_xflip,
    input  logic [INDEX_W-1:0] spr_index,
    input  logic               spr_pal,
    input  logic               spr_prio,
    input  logic [2:0]         spr_cgb_pal,
    input  logic [1:0]         main_color,
    input  logic               main_pal,
    input  logic               main_prio,
    input  logic [2:0]         main_cgb_pal,
    input  logic [INDEX_W-1:0] main_index,
    output logic [1:0]         out_color,
    output logic               out_pal,
    output logic               out_prio,
    output logic [2:0]         out_cgb_pal,
    output logic [INDEX_W-1:0] out_index,
    output logic               out_extra,
    output logic [2:0]         load_count
);

    localparam int         c_NUM_SLOTS = 8;
    localparam logic [2:0] c_COUNT_MAX = 3'(SPRITES_EXTRA);

    // Slot storage; slot 0 is the pixel currently being presented.
    logic [1:0]         r_color   [c_NUM_SLOTS];
    logic               r_pal     [c_NUM_SLOTS];
    logic               r_prio    [c_NUM_SLOTS];
    logic [2:0]         r_cgb_pal [c_NUM_SLOTS];
    logic [INDEX_W-1:0] r_index   [c_NUM_SLOTS];

    logic               r_load_guard;
    logic [2:0]         r_load_count;

    logic [1:0]         r_out_color;
    logic               r_out_pal;
    logic               r_out_prio;
    logic [2:0]         r_out_cgb_pal;
    logic [INDEX_W-1:0] r_out_index;
    logic               r_out_extra;

    // Post-shift view of the slots, then post-load view.
    logic [1:0]         w_sh_color   [c_NUM_SLOTS];
    logic               w_sh_pal     [c_NUM_SLOTS];
    logic               w_sh_prio    [c_NUM_SLOTS];
    logic [2:0]         w_sh_cgb_pal [c_NUM_SLOTS];
    logic [INDEX_W-1:0] w_sh_index   [c_NUM_SLOTS];

    logic [1:0]         w_nx_color   [c_NUM_SLOTS];
    logic               w_nx_pal     [c_NUM_SLOTS];
    logic               w_nx_prio    [c_NUM_SLOTS];
    logic [2:0]         w_nx_cgb_pal [c_NUM_SLOTS];
    logic [INDEX_W-1:0] w_nx_index   [c_NUM_SLOTS];

    logic               w_ld;

    // The guard keeps a spr_found held across non-shifting cycles from
    // loading the same sprite repeatedly at one h position.
    assign w_ld = spr_found & extra_spr_en & ~r_load_guard & ~line_start;

    generate
        for (genvar gi = 0; gi < c_NUM_SLOTS; gi++) begin : g_slot
            logic [1:0] w_px;
            logic       w_take;

            assign w_px = spr_xflip ? {spr_tile1[gi], spr_tile0[gi]}
                                    : {spr_tile1[c_NUM_SLOTS-1-gi], spr_tile0[c_NUM_SLOTS-1-gi]};

            if (gi == c_NUM_SLOTS - 1) begin : g_tail
                // A transparent, attribute-free pixel enters at the tail.
                assign w_sh_color[gi]   = pix_shift ? 2'b00       : r_color[gi];
                assign w_sh_pal[gi]     = pix_shift ? 1'b0        : r_pal[gi];
                assign w_sh_prio[gi]    = pix_shift ? 1'b0        : r_prio[gi];
                assign w_sh_cgb_pal[gi] = pix_shift ? 3'b000      : r_cgb_pal[gi];
                assign w_sh_index[gi]   = pix_shift ? {INDEX_W{1'b0}} : r_index[gi];
            end else begin : g_body
                assign w_sh_color[gi]   = pix_shift ? r_color[gi+1]   : r_color[gi];
                assign w_sh_pal[gi]     = pix_shift ? r_pal[gi+1]     : r_pal[gi];
                assign w_sh_prio[gi]    = pix_shift ? r_prio[gi+1]    : r_prio[gi];
                assign w_sh_cgb_pal[gi] = pix_shift ? r_cgb_pal[gi+1] : r_cgb_pal[gi];
                assign w_sh_index[gi]   = pix_shift ? r_index[gi+1]   : r_index[gi];
            end

            // DMG: an opaque slot is never replaced (earlier X wins).
            // CGB: a lower sprite index replaces an opaque slot.
            assign w_take = w_ld && (w_px != 2'b00) &&
                            ((w_sh_color[gi] == 2'b00) ||
                             (cgb_mode && (spr_index < w_sh_index[gi])));

            assign w_nx_color[gi]   = w_take ? w_px        : w_sh_color[gi];
            assign w_nx_pal[gi]     = w_take ? spr_pal     : w_sh_pal[gi];
            assign w_nx_prio[gi]    = w_take ? spr_prio    : w_sh_prio[gi];
            assign w_nx_cgb_pal[gi] = w_take ? spr_cgb_pal : w_sh_cgb_pal[gi];
            assign w_nx_index[gi]   = w_take ? spr_index   : w_sh_index[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_NUM_SLOTS; i++) begin
                r_color[i]   <= 2'b00;
                r_pal[i]     <= 1'b0;
                r_prio[i]    <= 1'b0;
                r_cgb_pal[i] <= 3'b000;
                r_index[i]   <= '0;
            end
            r_load_guard <= 1'b0;
            r_load_count <= 3'd0;
        end else if (ce) begin
            if (line_start) begin
                for (int i = 0; i < c_NUM_SLOTS; i++) begin
                    r_color[i]   <= 2'b00;
                    r_pal[i]     <= 1'b0;
                    r_prio[i]    <= 1'b0;
                    r_cgb_pal[i] <= 3'b000;
                    r_index[i]   <= '0;
                end
                r_load_guard <= 1'b0;
                r_load_count <= 3'd0;
            end else begin
                for (int i = 0; i < c_NUM_SLOTS; i++) begin
                    r_color[i]   <= w_nx_color[i];
                    r_pal[i]     <= w_nx_pal[i];
                    r_prio[i]    <= w_nx_prio[i];
                    r_cgb_pal[i] <= w_nx_cgb_pal[i];
                    r_index[i]   <= w_nx_index[i];
                end
                // The load follows the shift, so a load in a shifting cycle
                // leaves the guard set.
                if (w_ld) begin
                    r_load_guard <= 1'b1;
                end else if (pix_shift) begin
                    r_load_guard <= 1'b0;
                end
                // Counted even when the tile is fully transparent.
                if (w_ld && (r_load_count != c_COUNT_MAX)) begin
                    r_load_count <= r_load_count + 3'd1;
                end
            end
        end
    end

    // Main sprites always have lower OAM indices, so any opaque main pixel
    // wins over the extra path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_color   <= 2'b00;
            r_out_pal     <= 1'b0;
            r_out_prio    <= 1'b0;
            r_out_cgb_pal <= 3'b000;
            r_out_index   <= '0;
            r_out_extra   <= 1'b0;
        end else if (ce) begin
            if (!extra_spr_en || (main_color != 2'b00)) begin
                r_out_color   <= main_color;
                r_out_pal     <= main_pal;
                r_out_prio    <= main_prio;
                r_out_cgb_pal <= main_cgb_pal;
                r_out_index   <= main_index;
                r_out_extra   <= 1'b0;
            end else begin
                r_out_color   <= r_color[0];
                r_out_pal     <= r_pal[0];
                r_out_prio    <= r_prio[0];
                r_out_cgb_pal <= r_cgb_pal[0];
                r_out_index   <= r_index[0];
                r_out_extra   <= (r_color[0] != 2'b00);
            end
        end
    end

    assign out_color   = r_out_color;
    assign out_pal     = r_out_pal;
    assign out_prio    = r_out_prio;
    assign out_cgb_pal = r_out_cgb_pal;
    assign out_index   = r_out_index;
    assign out_extra   = r_out_extra;
    assign load_count  = r_load_count;

endmodule
`default_nettype wire

// File: tb/tb_sprites_extra_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprites_extra_shifter
// Purpose  : Self-checking bench for sprites_extra_shifter. Table-driven
//            per-cycle vectors whose expected outputs go into a scoreboard
//            queue when driven, and are popped and compared after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprites_extra_shifter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       extra_spr_en;
    logic       cgb_mode;
    logic       line_start;
    logic       pix_shift;
    logic       spr_found;
    logic [7:0] spr_tile0;
    logic [7:0] spr_tile1;
    logic       spr_xflip;
    logic [3:0] spr_index;
    logic       spr_pal;
    logic       spr_prio;
    logic [2:0] spr_cgb_pal;
    logic [1:0] main_color;
    logic       main_pal;
    logic       main_prio;
    logic [2:0] main_cgb_pal;
    logic [3:0] main_index;
    logic [1:0] out_color;
    logic       out_pal;
    logic       out_prio;
    logic [2:0] out_cgb_pal;
    logic [3:0] out_index;
    logic       out_extra;
    logic [2:0] load_count;

    always #5 clk = ~clk;

    sprites_extra_shifter #(
        .SPRITES_EXTRA (6),
        .INDEX_W       (4)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ce           (ce),
        .extra_spr_en (extra_spr_en),
        .cgb_mode     (cgb_mode),
        .line_start   (line_start),
        .pix_shift    (pix_shift),
        .spr_found    (spr_found),
        .spr_tile0    (spr_tile0),
        .spr_tile1    (spr_tile1),
        .spr_xflip    (spr_xflip),
        .spr_index    (spr_index),
        .spr_pal      (spr_pal),
        .spr_prio     (spr_prio),
        .spr_cgb_pal  (spr_cgb_pal),
        .main_color   (main_color),
        .main_pal     (main_pal),
        .main_prio    (main_prio),
        .main_cgb_pal (main_cgb_pal),
        .main_index   (main_index),
        .out_color    (out_color),
        .out_pal      (out_pal),
        .out_prio     (out_prio),
        .out_cgb_pal  (out_cgb_pal),
        .out_index    (out_index),
        .out_extra    (out_extra),
        .load_count   (load_count)
    );

    // Fixed attributes: every extra sprite uses pal=1 prio=0 cgb_pal=5,
    // the main pixel uses pal=0 prio=1 cgb_pal=2 index=3.
    typedef struct packed {
        logic       ce;
        logic       ls;
        logic       sh;
        logic       fnd;
        logic [7:0] t0;
        logic [7:0] t1;
        logic       xf;
        logic [3:0] idx;
        logic       cgb;
        logic       en;
        logic [1:0] mcol;
        logic       sel;   // 1 = expect slot-0 path, 0 = expect main path
        logic [1:0] ecol;
        logic [3:0] eidx;
        logic [2:0] ecnt;
    } vec_t;

    typedef struct packed {
        logic [1:0] color;
        logic       pal;
        logic       prio;
        logic [2:0] cgb;
        logic [3:0] index;
        logic       extra;
        logic [2:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t v(input int ce_i, input int ls, input int sh, input int fnd,
                               input int t0, input int t1, input int xf, input int idx,
                               input int cgb, input int en, input int mcol, input int sel,
                               input int ecol, input int eidx, input int ecnt);
        vec_t r;
        r.ce = 1'(ce_i);  r.ls = 1'(ls);   r.sh = 1'(sh);   r.fnd = 1'(fnd);
        r.t0 = 8'(t0);    r.t1 = 8'(t1);   r.xf = 1'(xf);   r.idx = 4'(idx);
        r.cgb = 1'(cgb);  r.en = 1'(en);   r.mcol = 2'(mcol); r.sel = 1'(sel);
        r.ecol = 2'(ecol); r.eidx = 4'(eidx); r.ecnt = 3'(ecnt);
        return r;
    endfunction

    function automatic exp_t expect_of(input vec_t r);
        exp_t e;
        e.cnt = r.ecnt;
        if (!r.sel) begin
            e.color = r.mcol; e.pal = 1'b0; e.prio = 1'b1; e.cgb = 3'd2;
            e.index = 4'd3;   e.extra = 1'b0;
        end else if (r.ecol != 2'b00) begin
            e.color = r.ecol; e.pal = 1'b1; e.prio = 1'b0; e.cgb = 3'd5;
            e.index = r.eidx; e.extra = 1'b1;
        end else begin
            e.color = 2'b00;  e.pal = 1'b0; e.prio = 1'b0; e.cgb = 3'd0;
            e.index = 4'd0;   e.extra = 1'b0;
        end
        return e;
    endfunction

    function automatic int sat6(input int x);
        return (x > 6) ? 6 : x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t r);
        exp_t e;
        ce           = r.ce;
        line_start   = r.ls;
        pix_shift    = r.sh;
        spr_found    = r.fnd;
        spr_tile0    = r.t0;
        spr_tile1    = r.t1;
        spr_xflip    = r.xf;
        spr_index    = r.idx;
        cgb_mode     = r.cgb;
        extra_spr_en = r.en;
        main_color   = r.mcol;
        sb.push_back(expect_of(r));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("out_color",   int'(out_color),   int'(e.color));
            chk("out_pal",     int'(out_pal),     int'(e.pal));
            chk("out_prio",    int'(out_prio),    int'(e.prio));
            chk("out_cgb_pal", int'(out_cgb_pal), int'(e.cgb));
            chk("out_index",   int'(out_index),   int'(e.index));
            chk("out_extra",   int'(out_extra),   int'(e.extra));
            chk("load_count",  int'(load_count),  int'(e.cnt));
        end
    endtask

    task automatic apply_all();
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        ce           = 1'b1;
        extra_spr_en = 1'b1;
        cgb_mode     = 1'b0;
        line_start   = 1'b0;
        pix_shift    = 1'b0;
        spr_found    = 1'b0;
        spr_tile0    = 8'h00;
        spr_tile1    = 8'h00;
        spr_xflip    = 1'b0;
        spr_index    = 4'd0;
        spr_pal      = 1'b1;
        spr_prio     = 1'b0;
        spr_cgb_pal  = 3'd5;
        main_color   = 2'b00;
        main_pal     = 1'b0;
        main_prio    = 1'b1;
        main_cgb_pal = 3'd2;
        main_index   = 4'd3;

        // Reset state with the clock running.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_color",   int'(out_color),   0);
        chk("rst_out_pal",     int'(out_pal),     0);
        chk("rst_out_prio",    int'(out_prio),    0);
        chk("rst_out_cgb_pal", int'(out_cgb_pal), 0);
        chk("rst_out_index",   int'(out_index),   0);
        chk("rst_out_extra",   int'(out_extra),   0);
        chk("rst_load_count",  int'(load_count),  0);
        reset_n = 1'b1;

        //             ce ls sh fnd t0     t1     xf idx cgb en mc sel ecol eidx cnt
        // DMG single sprite F0/00, with a ce=0 hold in the middle
        vecs.push_back(v(1, 1, 0, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 0, 0,  0));
        vecs.push_back(v(1, 0, 0, 1, 'hF0, 'h00, 0, 10, 0, 1, 0, 1, 0, 0,  1));
        vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 1, 10, 1));
        vecs.push_back(v(0, 0, 1, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 1, 10, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0, 0, 1, 0, 1, 1, 10, 1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0, 0, 1, 0, 1, 0, 0, 1));
        // xflip 01/01: only the first pixel is opaque (colour 3)
        vecs.push_back(v(1, 1, 0, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 0, 0,  0));
        vecs.push_back(v(1, 0, 0, 1, 'h01, 'h01, 1, 12, 0, 1, 0, 1, 0, 0,  1));
        vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 3, 12, 1));
        vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 0, 0,  1));
        vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 0, 0,  1));
        // DMG overlap: earlier sprite keeps pixels 0-5
        vecs.push_back(v(1, 1, 0, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 0, 0,  0));
        vecs.push_back(v(1, 0, 0, 1, 'hFF, 'h00, 0, 11, 0, 1, 0, 1, 0, 0,  1));
        vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 1, 11, 1));
        vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 1, 11, 1));
        vecs.push_back(v(1, 0, 0, 1, 'hFF, 'hFF, 0, 10, 0, 1, 0, 1, 1, 11, 2));
        for (int i = 0; i < 6; i++)
            vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0, 0, 1, 0, 1, 1, 11, 2));
        for (int i = 0; i < 2; i++)
            vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0, 0, 1, 0, 1, 3, 10, 2));
        // CGB overlap: lower index 10 takes every pixel
        vecs.push_back(v(1, 1, 0, 0, 'h00, 'h00, 0, 0,  1, 1, 0, 1, 0, 0,  0));
        vecs.push_back(v(1, 0, 0, 1, 'hFF, 'h00, 0, 11, 1, 1, 0, 1, 0, 0,  1));
        vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0,  1, 1, 0, 1, 1, 11, 1));
        vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0,  1, 1, 0, 1, 1, 11, 1));
        vecs.push_back(v(1, 0, 0, 1, 'hFF, 'hFF, 0, 10, 1, 1, 0, 1, 1, 11, 2));
        for (int i = 0; i < 8; i++)
            vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0, 1, 1, 0, 1, 3, 10, 2));
        // spr_found held 3 cycles without shifting: one load
        vecs.push_back(v(1, 1, 0, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 0, 0,  0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(1, 0, 0, 1, 'h80, 'h00, 0, 10, 0, 1, 0, 1,
                             (i == 0) ? 0 : 1, (i == 0) ? 0 : 10, 1));
        apply_all();

        // Eight more loads (transparent tiles still count): saturates at 6.
        for (int k = 0; k < 8; k++) begin
            run_vec(v(1, 0, 1, 0, 'h00, 'h00, 0, 0, 0, 1, 0, 1,
                      (k == 0) ? 1 : 0, (k == 0) ? 10 : 0, sat6(1 + k)));
            run_vec(v(1, 0, 0, 1, 'h00, 'h00, 0, 10, 0, 1, 0, 1, 0, 0, sat6(2 + k)));
        end

        //             ce ls sh fnd t0     t1     xf idx cgb en mc sel ecol eidx cnt
        vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 0, 0,  6));
        vecs.push_back(v(1, 0, 0, 1, 'hFF, 'h00, 0, 10, 0, 1, 0, 1, 0, 0,  6));
        vecs.push_back(v(1, 1, 0, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 1, 10, 0));
        vecs.push_back(v(1, 0, 0, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 0, 0,  0));
        // Main pixel over an opaque extra slot, then extra_spr_en masking
        vecs.push_back(v(1, 0, 0, 1, 'hFF, 'h00, 0, 10, 0, 1, 0, 1, 0, 0,  1));
        vecs.push_back(v(1, 0, 0, 0, 'h00, 'h00, 0, 0,  0, 1, 2, 0, 0, 0,  1));
        vecs.push_back(v(1, 0, 0, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 1, 10, 1));
        vecs.push_back(v(1, 0, 0, 0, 'h00, 'h00, 0, 0,  0, 0, 0, 0, 0, 0,  1));
        // line_start wins over shift and load in the same cycle
        vecs.push_back(v(1, 1, 1, 1, 'hFF, 'hFF, 0, 10, 0, 1, 0, 1, 1, 10, 0));
        vecs.push_back(v(1, 0, 0, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 0, 0,  0));
        vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 0, 0,  0));
        // Set up opaque slots for the asynchronous reset check
        vecs.push_back(v(1, 1, 0, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 0, 0,  0));
        vecs.push_back(v(1, 0, 0, 1, 'hFF, 'h00, 0, 10, 0, 1, 0, 1, 0, 0,  1));
        vecs.push_back(v(1, 0, 1, 0, 'h00, 'h00, 0, 0,  0, 1, 0, 1, 1, 10, 1));
        apply_all();

        // Mid-cycle reset: outputs and count must clear without a clock edge.
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_out_color",  int'(out_color),  0);
        chk("async_out_index",  int'(out_index),  0);
        chk("async_out_extra",  int'(out_extra),  0);
        chk("async_load_count", int'(load_count), 0);
        #1;
        reset_n = 1'b1;
        // Slot 0 held an opaque pixel before reset; it must now be empty.
        run_vec(v(1, 0, 0, 0, 'h00, 'h00, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        run_vec(v(1, 0, 1, 0, 'h00, 'h00, 0, 0, 0, 1, 0, 1, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
